conv_issue_engine: RTL and testbench
====================================

Name: conv_issue_engine

Overview:
- Front-end issue stage of the convolution accelerator.
- Enumerates every filter window of the current layer and assigns windows to allocators, one allocator per cycle ("positioning").
- Then streams (broadcasts) the image pixels those windows need, read from image memory, channel by channel.
- Asserts done when every window has been served. Sits between image memory and the allocator array.

Parameters:
- num_allocators, 220, number of allocator slots (width of positioner_select and issue_block).

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- imem_read_addr  out  16  image-memory read address.
- imem_read_data  in  18  image-memory read data, valid one cycle after the address.
- image_dim  in  8  image width = height, in pixels; held stable from reset to done.
- image_depth  in  9  channel count, 1..511.
- filter_halfsize  in  2  filter is (2h+1)x(2h+1).
- filter_stride  in  3  window-center step, 1..7.
- issue_x, issue_y  out  8 each  coordinates of the broadcast pixel.
- issue_data  out  18  broadcast pixel value.
- issue_en  out  1  broadcast valid.
- issue_block  in  num_allocators  per-allocator stall request.
- positioner_x, positioner_y  out  8 each  window center being assigned.
- positioner_select  out  num_allocators  one-hot allocator being assigned; all zero when idle.
- done  out  1  all work complete; sticky until reset.

Behaviour:
- Reset (async, rst=1): all outputs 0, all counters 0, state POSITION. Work starts on the first clk edge after rst falls.
- Window enumeration:
  - Centers (cx,cy) with cx,cy in {h, h+s, h+2s, ...} and <= image_dim-1-h.
  - Ordered raster: cx fastest, then cy.
  - If image_dim < 2h+1 there are no windows; done=1 on the first edge after reset.
- Batching: windows are consumed in batches of up to num_allocators consecutive windows. Window k of a batch goes to allocator k.
- POSITION state: one window per cycle.
  - positioner_select = 1<<k, positioner_x/y = center of window k. All three are registered outputs.
  - After the last window of the batch: positioner_select returns to 0 next cycle, go to ISSUE.
- ISSUE state:
  - Row span = first window cy-h through last window cy+h of the batch.
  - For c = 0..image_depth-1, for y in the row span, for x = 0..image_dim-1 (x fastest), read one pixel.
  - Address = (c*image_dim + y)*image_dim + x, truncated to 16 bits.
- Read pipeline: address driven in cycle N; in cycle N+1, issue_en=1 with issue_x/y/data = the pixel read in cycle N.
- Stall: if issue_block is nonzero in a cycle, the scan counters do not advance that cycle. The same address is re-presented, and issue_en in the following cycle is 0. No pixel is skipped or duplicated by a stall.
- Batch end: after the final read of a batch is issued, go to POSITION for the next batch, or to DONE if no windows remain.
- DONE: done=1 (held), issue_en=0, positioner_select=0, imem_read_addr held.
- Outputs are never asserted while in the other phase: positioner_select and issue_en are never simultaneously nonzero.
- Reset mid-operation: immediate return to the reset state; no partial outputs persist.
- Counter widths must cover image_dim up to 255 and depth up to 511 without overflow, except for the stated 16-bit address truncation.

Test Plan:
- dim=5, h=1, s=1, depth=1, num_allocators=4, block=0:
  - Positions (1,1),(2,1),(3,1),(1,2) on allocators 0..3, then 20 issues over rows 0..3.
  - Then (2,2),(3,2),(1,3),(2,3) and 20 issues over rows 1..4.
  - Then (3,3) on allocator 0 and 15 issues over rows 2..4.
  - 55 issues total, then done.
- Same setup with depth=2: each batch issues channel 0 then channel 1. The first address of channel 1 in batch 1 is 25; 110 issues total.
- Pipeline: with imem_read_data = address echo, every issue_data equals (c*25+y*5+x) for the accompanying issue_x/issue_y.
- Stall: hold issue_block=1 for 3 cycles mid-row. issue_en=0 during the stall; the stream resumes at the stalled pixel; the total issue count is unchanged.
- Stride/edge: dim=46, h=1, s=1, depth=3, num_allocators=220:
  - 1936 windows in 9 batches, centers 1..44.
  - Every pixel is issued a multiple of 3 times; done asserts and stays high.
- Degenerate and reset:
  - dim=2, h=1 -> done=1 one cycle after reset with no positioning.
  - Asserting rst mid-ISSUE clears all outputs asynchronously.

Source files
------------

// File: rtl/conv_issue_engine.sv
// Front-end issue stage: enumerates filter windows, hands them to allocators in batches,
// then broadcasts every image row those windows touch, channel by channel.
module conv_issue_engine #(
    parameter int num_allocators = 220
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [15:0]               imem_read_addr,
    input  logic [17:0]               imem_read_data,
    input  logic [7:0]                image_dim,
    input  logic [8:0]                image_depth,
    input  logic [1:0]                filter_halfsize,
    input  logic [2:0]                filter_stride,
    output logic [7:0]                issue_x,
    output logic [7:0]                issue_y,
    output logic [17:0]               issue_data,
    output logic                      issue_en,
    input  logic [num_allocators-1:0] issue_block,
    output logic [7:0]                positioner_x,
    output logic [7:0]                positioner_y,
    output logic [num_allocators-1:0] positioner_select,
    output logic                      done,
    output logic [1:0]                dbg_state
);
    localparam int KW = (num_allocators > 1) ? $clog2(num_allocators) : 1;

    typedef enum logic [1:0] {
        ST_POSITION = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_DONE     = 2'd2
    } state_t;

    state_t                    r_state, w_state;
    logic [KW-1:0]             r_k, w_k;
    // Window cursor holds (center - h) so that the reset value 0 is the first window.
    logic [8:0]                r_wx, w_wx, r_wy, w_wy;
    logic                      r_more, w_more;
    logic [7:0]                r_first_y, w_first_y, r_last_y, w_last_y;
    logic [8:0]                r_c, w_c;
    logic [7:0]                r_y, w_y, r_x, w_x;
    logic [15:0]               r_addr, w_addr, w_addr_calc;
    logic [num_allocators-1:0] r_sel, w_sel;
    logic [7:0]                r_px, w_px, r_py, w_py, r_ix, w_ix, r_iy, w_iy;
    logic                      r_ien, w_ien, r_done, w_done;

    logic [9:0] w_span, w_dim, w_step_x, w_wy_ext, w_nwy_ext;
    logic [8:0] w_nwx, w_nwy;
    logic       w_win_ok, w_x_fits, w_next_ok, w_k_last, w_x_end, w_y_end, w_c_end;

    assign w_span    = {7'd0, filter_halfsize, 1'b1};
    assign w_dim     = {2'd0, image_dim};
    assign w_wy_ext  = {1'b0, r_wy};
    assign w_win_ok  = (w_wy_ext + w_span) <= w_dim;
    assign w_step_x  = {1'b0, r_wx} + {7'd0, filter_stride};
    assign w_x_fits  = (w_step_x + w_span) <= w_dim;
    assign w_nwx     = w_x_fits ? w_step_x[8:0] : 9'd0;
    assign w_nwy     = w_x_fits ? r_wy : (r_wy + {6'd0, filter_stride});
    assign w_nwy_ext = {1'b0, w_nwy};
    assign w_next_ok = (w_nwy_ext + w_span) <= w_dim;
    assign w_k_last  = (int'(r_k) == num_allocators - 1);
    assign w_x_end   = (r_x == image_dim - 8'd1);
    assign w_y_end   = (r_y == r_last_y);
    assign w_c_end   = (r_c == image_depth - 9'd1);

    always_comb begin
        w_state   = r_state;
        w_k       = r_k;
        w_wx      = r_wx;
        w_wy      = r_wy;
        w_more    = r_more;
        w_first_y = r_first_y;
        w_last_y  = r_last_y;
        w_c       = r_c;
        w_y       = r_y;
        w_x       = r_x;
        w_sel     = '0;
        w_px      = r_px;
        w_py      = r_py;
        w_ien     = 1'b0;
        w_ix      = r_ix;
        w_iy      = r_iy;
        w_done    = r_done;
        case (r_state)
            ST_POSITION: begin
                if (!w_win_ok) begin
                    w_state = ST_DONE;
                    w_done  = 1'b1;
                end else begin
                    w_sel[r_k] = 1'b1;
                    w_px       = r_wx[7:0] + {6'd0, filter_halfsize};
                    w_py       = r_wy[7:0] + {6'd0, filter_halfsize};
                    w_last_y   = r_wy[7:0] + {5'd0, filter_halfsize, 1'b0};
                    if (r_k == '0) w_first_y = r_wy[7:0];
                    w_wx   = w_nwx;
                    w_wy   = w_nwy;
                    w_more = w_next_ok;
                    if (w_k_last || !w_next_ok) begin
                        w_state = ST_ISSUE;
                        w_k     = '0;
                        w_c     = 9'd0;
                        w_x     = 8'd0;
                        w_y     = (r_k == '0) ? r_wy[7:0] : r_first_y;
                    end else begin
                        w_k = r_k + 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                // Any stall request freezes the scan; the same address is re-presented.
                if (issue_block == '0) begin
                    w_ien = 1'b1;
                    w_ix  = r_x;
                    w_iy  = r_y;
                    if (w_x_end) begin
                        w_x = 8'd0;
                        if (w_y_end) begin
                            w_y = r_first_y;
                            if (w_c_end) w_state = r_more ? ST_POSITION : ST_DONE;
                            else         w_c = r_c + 9'd1;
                        end else begin
                            w_y = r_y + 8'd1;
                        end
                    end else begin
                        w_x = r_x + 8'd1;
                    end
                end
            end
            ST_DONE: w_done = 1'b1;
            default: w_state = ST_POSITION;
        endcase
    end

    // Arithmetic is mod 2^16, which is exactly the wanted address truncation.
    assign w_addr_calc = (((16'(w_c) * 16'(image_dim)) + 16'(w_y)) * 16'(image_dim)) + 16'(w_x);
    assign w_addr      = (w_state == ST_ISSUE) ? w_addr_calc : r_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_POSITION;
            r_k       <= '0;
            r_wx      <= 9'd0;
            r_wy      <= 9'd0;
            r_more    <= 1'b0;
            r_first_y <= 8'd0;
            r_last_y  <= 8'd0;
            r_c       <= 9'd0;
            r_y       <= 8'd0;
            r_x       <= 8'd0;
            r_addr    <= 16'd0;
            r_sel     <= '0;
            r_px      <= 8'd0;
            r_py      <= 8'd0;
            r_ien     <= 1'b0;
            r_ix      <= 8'd0;
            r_iy      <= 8'd0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_k       <= w_k;
            r_wx      <= w_wx;
            r_wy      <= w_wy;
            r_more    <= w_more;
            r_first_y <= w_first_y;
            r_last_y  <= w_last_y;
            r_c       <= w_c;
            r_y       <= w_y;
            r_x       <= w_x;
            r_addr    <= w_addr;
            r_sel     <= w_sel;
            r_px      <= w_px;
            r_py      <= w_py;
            r_ien     <= w_ien;
            r_ix      <= w_ix;
            r_iy      <= w_iy;
            r_done    <= w_done;
        end
    end

    assign imem_read_addr    = r_addr;
    assign issue_x           = r_ix;
    assign issue_y           = r_iy;
    assign issue_en          = r_ien;
    assign issue_data        = r_ien ? imem_read_data : 18'd0;
    assign positioner_x      = r_px;
    assign positioner_y      = r_py;
    assign positioner_select = r_sel;
    assign done              = r_done;
    assign dbg_state         = r_state;
endmodule

// File: tb/tb_conv_issue_engine.sv
// Bench for conv_issue_engine: two instances (4 and 220 allocators) checked against
// an event-list model of positions and broadcasts built from the window rules.
module tb_conv_issue_engine;
    typedef struct packed {
        logic        is_iss;
        logic [7:0]  idx;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [17:0] data;
    } ev_t;

    logic         clk, rst;
    logic [7:0]   image_dim;
    logic [8:0]   image_depth;
    logic [1:0]   filter_halfsize;
    logic [2:0]   filter_stride;
    logic [219:0] blk;
    logic         use_b, mem_mode, mon_en;

    logic [15:0]  addr_a, addr_b;
    logic [17:0]  rdata_a, rdata_b, idata_a, idata_b;
    logic [7:0]   ix_a, iy_a, px_a, py_a, ix_b, iy_b, px_b, py_b;
    logic         ien_a, ien_b, done_a, done_b;
    logic [3:0]   sel_a;
    logic [219:0] sel_b;
    logic [1:0]   dbg_a, dbg_b;

    logic [15:0]  o_addr;
    logic [17:0]  o_data;
    logic [7:0]   o_ix, o_iy, o_px, o_py;
    logic         o_en, o_done;
    logic [219:0] o_sel;

    ev_t exp_q[$];
    int  n_cmp, n_err, n_iss, last_cyc;
    bit  blk_prev;

    conv_issue_engine #(.num_allocators(4)) dut_a (
        .clk(clk), .rst(rst), .imem_read_addr(addr_a), .imem_read_data(rdata_a),
        .image_dim(image_dim), .image_depth(image_depth), .filter_halfsize(filter_halfsize),
        .filter_stride(filter_stride), .issue_x(ix_a), .issue_y(iy_a), .issue_data(idata_a),
        .issue_en(ien_a), .issue_block(blk[3:0]), .positioner_x(px_a), .positioner_y(py_a),
        .positioner_select(sel_a), .done(done_a), .dbg_state(dbg_a));

    conv_issue_engine #(.num_allocators(220)) dut_b (
        .clk(clk), .rst(rst), .imem_read_addr(addr_b), .imem_read_data(rdata_b),
        .image_dim(image_dim), .image_depth(image_depth), .filter_halfsize(filter_halfsize),
        .filter_stride(filter_stride), .issue_x(ix_b), .issue_y(iy_b), .issue_data(idata_b),
        .issue_en(ien_b), .issue_block(blk), .positioner_x(px_b), .positioner_y(py_b),
        .positioner_select(sel_b), .done(done_b), .dbg_state(dbg_b));

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [17:0] mem_word(input logic [15:0] a);
        return mem_mode ? {a[15:14] ^ a[1:0], a ^ 16'hA5C3} : {2'b00, a};
    endfunction

    // Synchronous image memory: data appears one cycle after the address.
    always @(posedge clk) begin
        rdata_a <= mem_word(addr_a);
        rdata_b <= mem_word(addr_b);
    end

    always_comb begin
        o_addr = use_b ? addr_b  : addr_a;
        o_data = use_b ? idata_b : idata_a;
        o_ix   = use_b ? ix_b    : ix_a;
        o_iy   = use_b ? iy_b    : iy_a;
        o_px   = use_b ? px_b    : px_a;
        o_py   = use_b ? py_b    : py_a;
        o_en   = use_b ? ien_b   : ien_a;
        o_done = use_b ? done_b  : done_a;
        o_sel  = use_b ? sel_b   : {216'd0, sel_a};
    end

    // Reference model: every window in raster order, chunked into batches; each batch
    // is its positions followed by every pixel of its row span for every channel.
    task automatic build_model(input int dim, input int h, input int s, input int depth, input int na);
        int  wxs[$];
        int  wys[$];
        ev_t e;
        exp_q.delete();
        for (int cy = h; cy <= dim - 1 - h; cy += s)
            for (int cx = h; cx <= dim - 1 - h; cx += s) begin
                wxs.push_back(cx);
                wys.push_back(cy);
            end
        for (int b = 0; b < wxs.size(); b += na) begin
            int last = (b + na < wxs.size()) ? b + na - 1 : wxs.size() - 1;
            for (int k = b; k <= last; k++) begin
                e = '0;
                e.idx = 8'(k - b);
                e.x = 8'(wxs[k]);
                e.y = 8'(wys[k]);
                exp_q.push_back(e);
            end
            for (int c = 0; c < depth; c++)
                for (int y = wys[b] - h; y <= wys[last] + h; y++)
                    for (int x = 0; x < dim; x++) begin
                        e = '0;
                        e.is_iss = 1'b1;
                        e.x = 8'(x);
                        e.y = 8'(y);
                        e.data = mem_word(16'(((c * dim + y) * dim) + x));
                        exp_q.push_back(e);
                    end
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        ev_t          e;
        bit           have;
        logic [219:0] es;
        if (mon_en) begin
            n_cmp++;
            assert (!((o_sel != '0) && o_en)) else begin
                n_err++;
                $error("FAIL phase_overlap: sel=%h issue_en=%b expected exclusive", o_sel, o_en);
            end
            if (blk_prev) begin
                n_cmp++;
                assert (o_en === 1'b0) else begin
                    n_err++;
                    $error("FAIL stall_bubble: issue_en=%b expected 0", o_en);
                end
            end
            if (o_sel != '0) begin
                have = (exp_q.size() > 0) && !exp_q[0].is_iss;
                n_cmp++;
                assert (have) else begin
                    n_err++;
                    $error("FAIL pos_order: unexpected select=%h x=%0d y=%0d (queue %0d)", o_sel, o_px, o_py, exp_q.size());
                end
                if (have) begin
                    e = exp_q.pop_front();
                    es = '0;
                    es[e.idx] = 1'b1;
                    n_cmp++;
                    assert ({o_sel, o_px, o_py} === {es, e.x, e.y}) else begin
                        n_err++;
                        $error("FAIL position: sel=%h x=%0d y=%0d expected sel=%h x=%0d y=%0d", o_sel, o_px, o_py, es, e.x, e.y);
                    end
                end
            end
            if (o_en) begin
                n_iss++;
                have = (exp_q.size() > 0) && exp_q[0].is_iss;
                n_cmp++;
                assert (have) else begin
                    n_err++;
                    $error("FAIL issue_order: unexpected issue x=%0d y=%0d data=%h (queue %0d)", o_ix, o_iy, o_data, exp_q.size());
                end
                if (have) begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    assert ({o_ix, o_iy, o_data} === {e.x, e.y, e.data}) else begin
                        n_err++;
                        $error("FAIL issue: x=%0d y=%0d data=%h expected x=%0d y=%0d data=%h", o_ix, o_iy, o_data, e.x, e.y, e.data);
                    end
                end
            end
            blk_prev = (blk != '0);
        end else begin
            blk_prev = 1'b0;
        end
    end

    task automatic check_all_zero(input string tag);
        n_cmp++;
        assert ({o_addr, o_ix, o_iy, o_data, o_en, o_px, o_py, o_sel, o_done} === '0) else begin
            n_err++;
            $error("FAIL %s: addr=%h ix=%0d iy=%0d data=%h en=%b px=%0d py=%0d sel=%h done=%b expected all 0",
                   tag, o_addr, o_ix, o_iy, o_data, o_en, o_px, o_py, o_sel, o_done);
        end
    endtask

    // Driver: one full layer run, optional random or directed stalls, optional mid-run reset.
    task automatic run_case(input string name, input int dim, input int h, input int s, input int depth,
                            input bit b_sel, input bit mode, input int stall_pct, input int stall_at,
                            input int exp_total, input int abort_at);
        int cyc;
        int na;
        int stall_left;
        bit finished;
        bit stalled;
        rst = 1'b1;
        mon_en = 1'b0;
        blk = '0;
        use_b = b_sel;
        mem_mode = mode;
        image_dim = 8'(dim);
        image_depth = 9'(depth);
        filter_halfsize = 2'(h);
        filter_stride = 3'(s);
        na = b_sel ? 220 : 4;
        build_model(dim, h, s, depth, na);
        n_iss = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        cyc = 0;
        finished = 1'b0;
        stalled = 1'b0;
        stall_left = 0;
        while (!finished && cyc < 40000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (o_done) begin
                finished = 1'b1;
            end else if (abort_at >= 0 && n_iss >= abort_at) begin
                mon_en = 1'b0;
                blk = '0;
                #2;
                rst = 1'b1;
                #1;
                check_all_zero({name, "_async_reset"});
                @(posedge clk);
                #1;
                check_all_zero({name, "_reset_hold"});
                exp_q.delete();
                return;
            end
            blk = '0;
            if (stall_at >= 0 && !stalled && n_iss == stall_at) begin
                stall_left = 3;
                stalled = 1'b1;
            end
            if (stall_left > 0) begin
                blk[$urandom_range(0, na - 1)] = 1'b1;
                stall_left--;
            end else if (stall_pct > 0 && $urandom_range(0, 99) < stall_pct) begin
                blk[$urandom_range(0, na - 1)] = 1'b1;
            end
        end
        blk = '0;
        last_cyc = cyc;
        n_cmp++;
        assert (finished) else begin
            n_err++;
            $error("FAIL %s_timeout: done not seen after %0d cycles", name, cyc);
        end
        n_cmp++;
        assert (exp_q.size() == 0) else begin
            n_err++;
            $error("FAIL %s_leftover: %0d expected events never observed, expected 0", name, exp_q.size());
        end
        if (exp_total >= 0) begin
            n_cmp++;
            assert (n_iss == exp_total) else begin
                n_err++;
                $error("FAIL %s_issue_count: got %0d expected %0d", name, n_iss, exp_total);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        assert ({o_done, o_en, o_sel} === {1'b1, 1'b0, 220'd0}) else begin
            n_err++;
            $error("FAIL %s_done_hold: done=%b en=%b sel=%h expected done=1 en=0 sel=0", name, o_done, o_en, o_sel);
        end
        mon_en = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        n_iss = 0;
        last_cyc = 0;
        blk_prev = 1'b0;
        mon_en = 1'b0;
        rst = 1'b1;
        blk = '0;
        use_b = 1'b0;
        mem_mode = 1'b0;
        image_dim = 8'd5;
        image_depth = 9'd1;
        filter_halfsize = 2'd1;
        filter_stride = 3'd1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_a");
        use_b = 1'b1;
        #1;
        check_all_zero("reset_b");

        run_case("basic_d1", 5, 1, 1, 1, 1'b0, 1'b0, 0, -1, 55, -1);
        run_case("basic_d2_stall", 5, 1, 1, 2, 1'b0, 1'b0, 0, 7, 110, -1);
        run_case("stride2_rand", $urandom_range(7, 12), 1, 2, $urandom_range(1, 3), 1'b0, 1'b1, 20, -1, -1, -1);
        run_case("h2_s3_rand", 20, 2, 3, 2, 1'b0, 1'b1, 15, -1, -1, -1);
        run_case("h0_rand", $urandom_range(3, 6), 0, 1, 2, 1'b0, 1'b1, 10, -1, -1, -1);
        run_case("h3_s7", $urandom_range(7, 15), 3, 7, $urandom_range(1, 2), 1'b0, 1'b1, 10, -1, -1, -1);

        run_case("degenerate_a", 2, 1, 1, 1, 1'b0, 1'b0, 0, -1, 0, -1);
        n_cmp++;
        assert (last_cyc == 1) else begin
            n_err++;
            $error("FAIL degenerate_latency: done after %0d cycles expected 1", last_cyc);
        end
        run_case("degenerate_b", 6, 3, 2, 4, 1'b1, 1'b0, 0, -1, 0, -1);
        n_cmp++;
        assert (last_cyc == 1) else begin
            n_err++;
            $error("FAIL degenerate_b_latency: done after %0d cycles expected 1", last_cyc);
        end

        run_case("mid_issue_reset", 5, 1, 1, 2, 1'b0, 1'b0, 0, -1, -1, 10);
        run_case("after_reset", 5, 1, 1, 1, 1'b0, 1'b0, 0, -1, 55, -1);
        run_case("big_220", 46, 1, 1, 3, 1'b1, 1'b1, 5, -1, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
